// File: rtl/prf_wb_arbiter.sv
// Round-robin writeback arbiter: NUM_REQ result sources onto NUM_WR
// registered PRF write ports, with a sticky same-index collision flag.
module prf_wb_arbiter #(
  parameter int NUM_REQ  = 6,
  parameter int NUM_WR   = 2,
  parameter int PR_IDX_W = 7,
  parameter int DATA_W   = 64,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         wb_hold,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PR_IDX_W-1:0]  req_pr_idx,
  input  logic [NUM_REQ*DATA_W-1:0]    req_value,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_WR-1:0]            wr_enable,
  output logic [NUM_WR*PR_IDX_W-1:0]   wr_pr_idx,
  output logic [NUM_WR*DATA_W-1:0]     wr_value,
  output logic [PTR_W-1:0]             rr_ptr_o,
  output logic                         dup_idx_err
);

  logic [PTR_W-1:0]           r_ptr;
  logic [NUM_WR-1:0]          r_en;
  logic [NUM_WR*PR_IDX_W-1:0] r_idx;
  logic [NUM_WR*DATA_W-1:0]   r_val;
  logic                       r_dup;

  logic [NUM_REQ-1:0]         w_ready;
  logic [NUM_WR-1:0]          w_en;
  logic [NUM_WR*PR_IDX_W-1:0] w_idx;
  logic [NUM_WR*DATA_W-1:0]   w_val;
  logic [PTR_W-1:0]           w_ptr_nxt;
  logic                       w_dup;

  // Scan from r_ptr; the n-th valid requester found lands on port n.
  always_comb begin
    int n;
    int p;
    w_ready   = '0;
    w_en      = '0;
    w_idx     = '0;
    w_val     = '0;
    w_ptr_nxt = r_ptr;
    w_dup     = 1'b0;
    n         = 0;
    p         = 0;
    if (reset_n && !wb_hold) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        p = int'(r_ptr) + j;
        if (p >= NUM_REQ) p = p - NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (i == p && req_valid[i] && n < NUM_WR) begin
            w_ready[i] = 1'b1;
            for (int k = 0; k < NUM_WR; k++) begin
              if (k == n) begin
                w_en[k] = 1'b1;
                w_idx[k*PR_IDX_W +: PR_IDX_W] =
                  req_pr_idx[i*PR_IDX_W +: PR_IDX_W];
                w_val[k*DATA_W +: DATA_W] =
                  req_value[i*DATA_W +: DATA_W];
              end
            end
            w_ptr_nxt = (i == NUM_REQ-1) ? '0 : PTR_W'(i+1);
            n = n + 1;
          end
        end
      end
    end
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (w_en[a] && w_en[b] &&
            w_idx[a*PR_IDX_W +: PR_IDX_W] ==
            w_idx[b*PR_IDX_W +: PR_IDX_W])
          w_dup = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
      r_en  <= '0;
      r_idx <= '0;
      r_val <= '0;
      r_dup <= 1'b0;
    end else begin
      r_ptr <= w_ptr_nxt;
      r_en  <= w_en;
      for (int k = 0; k < NUM_WR; k++) begin
        if (w_en[k]) begin
          r_idx[k*PR_IDX_W +: PR_IDX_W] <=
            w_idx[k*PR_IDX_W +: PR_IDX_W];
          r_val[k*DATA_W +: DATA_W] <=
            w_val[k*DATA_W +: DATA_W];
        end
      end
      if (w_dup) r_dup <= 1'b1;
    end
  end

  assign req_ready   = w_ready;
  assign wr_enable   = r_en;
  assign wr_pr_idx   = r_idx;
  assign wr_value    = r_val;
  assign rr_ptr_o    = r_ptr;
  assign dup_idx_err = r_dup;

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Bench for prf_wb_arbiter: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_prf_wb_arbiter;

  localparam int NREQ = 6;
  localparam int NWR  = 2;
  localparam int IW   = 7;
  localparam int DW   = 64;

  typedef int q_t[$];

  logic              clock;
  logic              reset_n;
  logic              wb_hold;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*IW-1:0] req_pr_idx;
  logic [NREQ*DW-1:0] req_value;
  logic [NREQ-1:0]   req_ready;
  logic [NWR-1:0]    wr_enable;
  logic [NWR*IW-1:0] wr_pr_idx;
  logic [NWR*DW-1:0] wr_value;
  logic [2:0]        rr_ptr_o;
  logic              dup_idx_err;

  logic [IW-1:0] t_idx [NREQ];
  logic [DW-1:0] t_val [NREQ];

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  int            m_ptr = 0;
  logic [NWR-1:0] m_en = '0;
  logic [IW-1:0] m_idx [NWR] = '{default: '0};
  logic [DW-1:0] m_val [NWR] = '{default: '0};
  logic          m_dup = 1'b0;

  prf_wb_arbiter #(
    .NUM_REQ(NREQ), .NUM_WR(NWR),
    .PR_IDX_W(IW), .DATA_W(DW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .wb_hold(wb_hold), .req_valid(req_valid),
    .req_pr_idx(req_pr_idx), .req_value(req_value),
    .req_ready(req_ready), .wr_enable(wr_enable),
    .wr_pr_idx(wr_pr_idx), .wr_value(wr_value),
    .rr_ptr_o(rr_ptr_o), .dup_idx_err(dup_idx_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    req_pr_idx = '0;
    req_value  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_pr_idx[i*IW +: IW] = t_idx[i];
      req_value[i*DW +: DW]  = t_val[i];
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Valid requesters at or above the pointer come first in ascending
  // order, then the ones below it; the first NWR of that list win.
  function automatic q_t model_grants(input int ptr,
                                      input logic [NREQ-1:0] v,
                                      input logic h);
    q_t hi;
    q_t lo;
    if (h) return hi;
    for (int i = 0; i < NREQ; i++) begin
      if (v[i]) begin
        if (i >= ptr) hi.push_back(i);
        else lo.push_back(i);
      end
    end
    foreach (lo[i]) hi.push_back(lo[i]);
    while (hi.size() > NWR) void'(hi.pop_back());
    return hi;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    q_t g;
    if (!reset_n) begin
      m_ptr <= 0;
      m_en  <= '0;
      for (int k = 0; k < NWR; k++) begin
        m_idx[k] <= '0;
        m_val[k] <= '0;
      end
      m_dup <= 1'b0;
    end else begin
      g = model_grants(m_ptr, req_valid, wb_hold);
      for (int k = 0; k < NWR; k++) begin
        if (k < g.size()) begin
          m_en[k]  <= 1'b1;
          m_idx[k] <= t_idx[g[k]];
          m_val[k] <= t_val[g[k]];
        end else begin
          m_en[k] <= 1'b0;
        end
      end
      for (int a = 0; a < g.size(); a++)
        for (int b = a + 1; b < g.size(); b++)
          if (t_idx[g[a]] == t_idx[g[b]]) m_dup <= 1'b1;
      if (g.size() > 0)
        m_ptr <= (g[g.size()-1] + 1) % NREQ;
    end
  end

  always @(negedge clock) begin
    q_t g;
    logic [NREQ-1:0] er;
    if (cmp_en) begin
      er = '0;
      if (reset_n) begin
        g = model_grants(m_ptr, req_valid, wb_hold);
        foreach (g[k]) er[g[k]] = 1'b1;
      end
      chk("cmp_ready", 64'(req_ready), 64'(er));
      chk("cmp_wr_en", 64'(wr_enable), 64'(m_en));
      for (int k = 0; k < NWR; k++) begin
        chk("cmp_wr_idx", 64'(wr_pr_idx[k*IW +: IW]),
            64'(m_idx[k]));
        chk("cmp_wr_val", wr_value[k*DW +: DW], m_val[k]);
      end
      chk("cmp_ptr", 64'(rr_ptr_o), 64'(m_ptr));
      chk("cmp_dup", 64'(dup_idx_err), 64'(m_dup));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic restore();
    for (int i = 0; i < NREQ; i++) begin
      t_idx[i] = IW'(40 + i);
      t_val[i] = 64'h1000 + 64'(i);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    wb_hold   = 1'b0;
    req_valid = '0;
    restore();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    chk("rst_ptr", 64'(rr_ptr_o), 64'd0);
    chk("rst_en", 64'(wr_enable), 64'd0);
    chk("rst_dup", 64'(dup_idx_err), 64'd0);

    // single request
    t_idx[2]  = 7'd33;
    t_val[2]  = 64'hDEAD;
    req_valid = 6'b000100;
    neg();
    chk("single_ready", 64'(req_ready), 64'b000100);
    step();
    req_valid = '0;
    chk("single_en", 64'(wr_enable), 64'b01);
    chk("single_idx", 64'(wr_pr_idx[6:0]), 64'd33);
    chk("single_val", wr_value[63:0], 64'hDEAD);
    chk("single_ptr", 64'(rr_ptr_o), 64'd3);
    restore();

    // bring pointer back to 0 (grants 4,5)
    req_valid = 6'b110000;
    step();
    chk("prep_ptr", 64'(rr_ptr_o), 64'd0);

    // all valid for three cycles
    req_valid = 6'b111111;
    for (int c = 0; c < 3; c++) begin
      logic [NREQ-1:0] e;
      e = 6'b000011 << (2 * c);
      neg();
      chk("all_ready", 64'(req_ready), 64'(e));
      step();
      chk("all_en", 64'(wr_enable), 64'b11);
      chk("all_idx0", 64'(wr_pr_idx[6:0]), 64'(40 + 2*c));
      chk("all_idx1", 64'(wr_pr_idx[13:7]), 64'(41 + 2*c));
      chk("all_ptr", 64'(rr_ptr_o), 64'((2*c + 2) % 6));
    end
    req_valid = '0;

    // wrap-around from pointer 5
    req_valid = 6'b010000;
    step();
    chk("wrap_prep_ptr", 64'(rr_ptr_o), 64'd5);
    req_valid = 6'b100001;
    neg();
    chk("wrap_ready", 64'(req_ready), 64'b100001);
    step();
    req_valid = '0;
    chk("wrap_idx0", 64'(wr_pr_idx[6:0]), 64'd45);
    chk("wrap_idx1", 64'(wr_pr_idx[13:7]), 64'd40);
    chk("wrap_ptr", 64'(rr_ptr_o), 64'd1);

    // hold
    wb_hold   = 1'b1;
    req_valid = 6'b111111;
    neg();
    chk("hold_ready", 64'(req_ready), 64'd0);
    step();
    chk("hold_en", 64'(wr_enable), 64'd0);
    chk("hold_ptr", 64'(rr_ptr_o), 64'd1);
    wb_hold = 1'b0;
    neg();
    chk("resume_ready", 64'(req_ready), 64'b000110);
    step();
    req_valid = '0;
    chk("resume_ptr", 64'(rr_ptr_o), 64'd3);

    // duplicate index
    chk("dup_before", 64'(dup_idx_err), 64'd0);
    t_idx[1]  = 7'd10;
    t_idx[2]  = 7'd10;
    req_valid = 6'b000110;
    neg();
    chk("dup_ready", 64'(req_ready), 64'b000110);
    step();
    req_valid = '0;
    chk("dup_en", 64'(wr_enable), 64'b11);
    chk("dup_idx0", 64'(wr_pr_idx[6:0]), 64'd10);
    chk("dup_idx1", 64'(wr_pr_idx[13:7]), 64'd10);
    chk("dup_val0", wr_value[63:0], 64'h1001);
    chk("dup_val1", wr_value[127:64], 64'h1002);
    chk("dup_set", 64'(dup_idx_err), 64'd1);
    repeat (3) step();
    chk("dup_sticky", 64'(dup_idx_err), 64'd1);
    restore();

    // reset in the middle of a double write
    req_valid = 6'b111111;
    step();
    chk("mid_en", 64'(wr_enable), 64'b11);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_en", 64'(wr_enable), 64'd0);
    chk("mid_rst_idx", 64'(wr_pr_idx), 64'd0);
    chk("mid_rst_val", wr_value[63:0] | wr_value[127:64], 64'd0);
    chk("mid_rst_ptr", 64'(rr_ptr_o), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_dup", 64'(dup_idx_err), 64'd0);
    step();
    reset_n = 1'b1;
    neg();
    chk("post_rst_ready", 64'(req_ready), 64'b000011);
    step();
    chk("post_rst_ptr", 64'(rr_ptr_o), 64'd2);
    req_valid = '0;
    step();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
